// File: rtl/led_trail_pwm.sv
// rtl/led_trail_pwm.sv - per-channel decaying PWM trail behind the one-hot LED stepper
// Optional feature macro: LED_TRAIL_GAMMA_EN (squared PWM thresholds for a perceptual fade).
module led_trail_pwm #(
    parameter int NUM_LEDS   = 10,
    parameter int PWM_BITS   = 8,
    parameter int DECAY_DIV  = 1250000,
    parameter int DECAY_STEP = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_LEDS-1:0] led_in,
    output logic [NUM_LEDS-1:0] led_out
);
    localparam int                PRE_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DECAY_DIV - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
    localparam logic [31:0]       STEP32   = 32'(DECAY_STEP);

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic                decay_tick;
    logic [PWM_BITS-1:0] level_q [NUM_LEDS];
    logic [PWM_BITS-1:0] level_d [NUM_LEDS];
    logic [NUM_LEDS-1:0] led_out_q, led_out_d;

    // Brightness-to-threshold map; the square keeps low levels dim for longer.
    function automatic logic [PWM_BITS-1:0] thr_f(input logic [PWM_BITS-1:0] lvl);
`ifdef LED_TRAIL_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        sq = {PWM_BITS'(0), lvl} * {PWM_BITS'(0), lvl};
        return sq[2*PWM_BITS-1:PWM_BITS];
`else
        return lvl;
`endif
    endfunction

    assign decay_tick = (pre_q == PRE_LAST);
    assign pre_d      = decay_tick ? '0 : pre_q + PRE_W'(1);
    assign pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);

    always_comb begin
        led_out_d = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            level_d[i] = level_q[i];
            if (led_in[i]) begin
                level_d[i] = LVL_MAX;
            end else if (decay_tick) begin
                // Compare in 32 bits so a step larger than MAX still saturates at zero.
                level_d[i] = (32'(level_q[i]) > STEP32) ? PWM_BITS'(32'(level_q[i]) - STEP32) : '0;
            end
            led_out_d[i] = (pwm_cnt_q < thr_f(level_q[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q <= '0;
            pre_q     <= '0;
            level_q   <= '{default: '0};
            led_out_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            pre_q     <= pre_d;
            level_q   <= level_d;
            led_out_q <= led_out_d;
        end
    end

    assign led_out = led_out_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// tb/tb_led_trail_pwm.sv - self-checking bench for led_trail_pwm
// Optional feature macro: LED_TRAIL_GAMMA_EN (changes expected thresholds).
module tb_led_trail_pwm;
    localparam int N    = 10;
    localparam int PB   = 4;
    localparam int DIV  = 4;
    localparam int STEP = 3;
    localparam int MAXL = 15;
    localparam int PER  = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] led_in = '0;
    logic [N-1:0] led_out;
    logic         rst2 = 1'b1;
    logic [1:0]   led_in2 = '0;
    logic [1:0]   led_out2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_trail_pwm #(.NUM_LEDS(N), .PWM_BITS(PB), .DECAY_DIV(DIV), .DECAY_STEP(STEP)) dut (
        .clk(clk), .rst(rst), .led_in(led_in), .led_out(led_out)
    );

    led_trail_pwm #(.NUM_LEDS(2), .PWM_BITS(PB), .DECAY_DIV(64), .DECAY_STEP(7)) dut2 (
        .clk(clk), .rst(rst2), .led_in(led_in2), .led_out(led_out2)
    );

    function automatic int thr_m(input int l);
`ifdef LED_TRAIL_GAMMA_EN
        return (l * l) / PER;
`else
        return l;
`endif
    endfunction

    // Reference: n counts edges since reset release; the PWM phase is n mod PER
    // and a decay tick falls on every DIV-th edge.
    int           m_lvl [N];
    int           m_n = 0;
    logic [N-1:0] m_out = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_n   = 0;
            m_out = '0;
            for (int i = 0; i < N; i++) m_lvl[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) m_out[i] = ((m_n % PER) < thr_m(m_lvl[i]));
            for (int i = 0; i < N; i++) begin
                if (led_in[i]) m_lvl[i] = MAXL;
                else if ((m_n % DIV) == DIV - 1) m_lvl[i] = (m_lvl[i] > STEP) ? m_lvl[i] - STEP : 0;
            end
            m_n++;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (led_out !== m_out) begin
            errors++;
            $display("FAIL led_out_model t=%0t got %h want %h", $time, led_out, m_out);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [N-1:0] v);
        rst    = r;
        led_in = v;
        @(negedge clk);
    endtask

    int cnt0, cnt9, prev, lv, nchg;
    int vals [8];
    int idx  [8];

    initial begin
        // Reset with all inputs high, then steady full-on duty.
        cyc(1'b1, 10'h3FF);
        chk("rst_out0", int'(led_out), 0);
        cyc(1'b1, 10'h3FF);
        chk("rst_out1", int'(led_out), 0);
        cyc(1'b0, 10'h3FF);
        chk("lat_edge0", int'(led_out), 0);
        cyc(1'b0, 10'h3FF);
        chk("lat_edge1", int'(led_out), 10'h3FF);
        cnt0 = 0;
        cnt9 = 0;
        for (int k = 0; k < PER; k++) begin
            cyc(1'b0, 10'h3FF);
            cnt0 += int'(led_out[0]);
            cnt9 += int'(led_out[9]);
        end
`ifdef LED_TRAIL_GAMMA_EN
        chk("duty_max_ch0", cnt0, 14);
        chk("duty_max_ch9", cnt9, 14);
`else
        chk("duty_max_ch0", cnt0, 15);
        chk("duty_max_ch9", cnt9, 15);
`endif

        // Single-channel fade: 15,12,9,6,3,0 at 4-cycle spacing, no wrap.
        cyc(1'b1, '0);
        for (int k = 0; k < 8; k++) cyc(1'b0, 10'h001);
        chk("fade_start", int'(dut.level_q[0]), 15);
        prev = 15;
        nchg = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(1'b0, '0);
            lv = int'(dut.level_q[0]);
            if (lv != prev && nchg < 8) begin
                vals[nchg] = lv;
                idx[nchg]  = k;
                nchg++;
            end
            prev = lv;
        end
        chk("fade_nchg", nchg, 5);
        for (int j = 0; j < 5; j++) begin
            chk("fade_val", vals[j], 12 - 3 * j);
            chk("fade_gap", idx[j], 3 + 4 * j);
        end
        chk("fade_floor", lv, 0);

        // Set on the tick cycle wins over decay.
        cyc(1'b1, '0);
        cyc(1'b0, 10'h001);
        cyc(1'b0, '0);
        cyc(1'b0, '0);
        cyc(1'b0, 10'h001);
        chk("tick_override", int'(dut.level_q[0]), 15);
        for (int k = 0; k < 4; k++) cyc(1'b0, '0);
        chk("after_override", int'(dut.level_q[0]), 12);

        // Stepper pattern: independent trailing channels.
        cyc(1'b1, '0);
        for (int k = 0; k < 8; k++) cyc(1'b0, 10'h001);
        for (int k = 0; k < 8; k++) cyc(1'b0, 10'h002);
        for (int k = 0; k < 8; k++) cyc(1'b0, 10'h004);
        chk("trail_a_ch0", int'(dut.level_q[0]), 3);
        chk("trail_a_ch1", int'(dut.level_q[1]), 9);
        chk("trail_a_ch2", int'(dut.level_q[2]), 15);
        for (int k = 0; k < 8; k++) cyc(1'b0, '0);
        chk("trail_b_ch0", int'(dut.level_q[0]), 0);
        chk("trail_b_ch1", int'(dut.level_q[1]), 3);
        chk("trail_b_ch2", int'(dut.level_q[2]), 9);

        // Reset mid-fade, then prescaler restarts from zero.
        cyc(1'b1, '0);
        cyc(1'b0, 10'h001);
        for (int k = 0; k < 7; k++) cyc(1'b0, '0);
        chk("mid_level", int'(dut.level_q[0]), 9);
        cyc(1'b1, '0);
        chk("mid_rst_level", int'(dut.level_q[0]), 0);
        chk("mid_rst_out", int'(led_out), 0);
        cyc(1'b0, 10'h001);
        cyc(1'b0, '0);
        cyc(1'b0, '0);
        chk("restart_pre", int'(dut.level_q[0]), 15);
        cyc(1'b0, '0);
        chk("restart_tick", int'(dut.level_q[0]), 12);

        // Second instance holds level 8 long enough to measure one full PWM period.
        rst2    = 1'b0;
        led_in2 = 2'b01;
        cyc(1'b1, '0);
        led_in2 = 2'b00;
        for (int k = 0; k < 70; k++) cyc(1'b1, '0);
        cnt0 = 0;
        cnt9 = 0;
        for (int k = 0; k < PER; k++) begin
            cyc(1'b1, '0);
            cnt0 += int'(led_out2[0]);
            cnt9 += int'(led_out2[1]);
        end
`ifdef LED_TRAIL_GAMMA_EN
        chk("lvl8_duty", cnt0, 4);
`else
        chk("lvl8_duty", cnt0, 8);
`endif
        chk("lvl8_idle_ch", cnt9, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
